// File: rtl/jtsdram_pkg.sv
// Shared types and constants for the SDRAM checker pass controller.
// Bank keys are spaced KEY_STEP apart and rotate by one per round.
package jtsdram_pkg;

  localparam int unsigned KEY_W    = 5;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned KEY_STEP = 7;
  localparam int unsigned N_BANKS  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROG,
    ST_PROG_WAIT,
    ST_RD,
    ST_RD_WAIT,
    ST_NEXT,
    ST_DONE,
    ST_FAIL
  } state_t;

  typedef logic [KEY_W-1:0] key_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Wraps mod 2^KEY_W by construction of the return width.
  function automatic key_t bank_key(input cnt_t round, input int unsigned bank);
    key_t step;
    step = key_t'(KEY_STEP * bank);
    return round[KEY_W-1:0] + step;
  endfunction

endpackage

// File: rtl/jtsdram_watchdog.sv
// Wait-state watchdog: reloads on entry to a wait state, counts while enabled,
// flags expiry once the wait has lasted 2^TIMEOUT_W-1 cycles.
module jtsdram_watchdog #(
  parameter int unsigned TIMEOUT_W = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  typedef logic [TIMEOUT_W-1:0] wd_t;

  wd_t cnt;

  // Loading 1 rather than 0 makes the count equal the number of wait cycles
  // already spent, so all-ones lands on wait cycle 2^TIMEOUT_W-1.
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= wd_t'(1);
    else if (en && !expired)
      cnt <= cnt + wd_t'(1);
  end

  assign expired = en && (cnt == '1);

endmodule

// File: rtl/jtsdram_pass_ctrl.sv
// Run-time test scheduler: rounds of one programming phase followed by
// RD_PASSES read-verify passes, with per-bank keys and sticky fail/timeout.
module jtsdram_pass_ctrl
  import jtsdram_pkg::*;
#(
  parameter int unsigned RD_PASSES   = 4,
  parameter int unsigned ROUNDS      = 0,
  parameter int unsigned TIMEOUT_W   = 24,
  parameter int unsigned STOP_ON_BAD = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             bad,
  input  logic             prog_done,
  input  logic             ba0_done,
  input  logic             ba1_done,
  input  logic             ba2_done,
  input  logic             ba3_done,
  output logic             prog_start,
  output logic             rd_start,
  output logic [KEY_W-1:0] ba0_key,
  output logic [KEY_W-1:0] ba1_key,
  output logic [KEY_W-1:0] ba2_key,
  output logic [KEY_W-1:0] ba3_key,
  output logic             busy,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] round_cnt,
  output logic [CNT_W-1:0] pass_cnt
);

  state_t          state;
  key_t            keys [N_BANKS];
  logic [3:0]      done_q;
  logic [3:0]      done_nxt;
  cnt_t            rd_in_round;
  cnt_t            round_inc;
  logic            stop_req;
  logic            wd_load;
  logic            wd_en;
  logic            wd_expired;

  assign busy = !(state inside {ST_IDLE, ST_DONE, ST_FAIL});

  assign done_nxt  = done_q | {ba3_done, ba2_done, ba1_done, ba0_done};
  assign round_inc = round_cnt + cnt_t'(1);

  assign wd_load = (state == ST_PROG) || (state == ST_RD);
  assign wd_en   = (state == ST_PROG_WAIT) || (state == ST_RD_WAIT);

  assign ba0_key = keys[0];
  assign ba1_key = keys[1];
  assign ba2_key = keys[2];
  assign ba3_key = keys[3];

  jtsdram_watchdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (wd_load),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      prog_start  <= 1'b0;
      rd_start    <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      round_cnt   <= '0;
      pass_cnt    <= '0;
      rd_in_round <= '0;
      stop_req    <= 1'b0;
      done_q      <= '0;
      for (int unsigned n = 0; n < N_BANKS; n++)
        keys[n] <= bank_key('0, n);
    end else begin
      prog_start <= 1'b0;
      rd_start   <= 1'b0;
      if (busy && stop) stop_req <= 1'b1;
      if (busy && bad)  fail     <= 1'b1;

      // Abort on bad takes precedence so no start pulse leaves the block.
      if (busy && bad && (STOP_ON_BAD != 0)) begin
        state <= ST_FAIL;
      end else begin
        unique case (state)
          ST_IDLE, ST_DONE, ST_FAIL: begin
            if (start) begin
              fail        <= 1'b0;
              timeout     <= 1'b0;
              round_cnt   <= '0;
              pass_cnt    <= '0;
              rd_in_round <= '0;
              stop_req    <= 1'b0;
              for (int unsigned n = 0; n < N_BANKS; n++)
                keys[n] <= bank_key('0, n);
              prog_start  <= 1'b1;
              state       <= ST_PROG;
            end
          end
          ST_PROG: state <= ST_PROG_WAIT;
          ST_PROG_WAIT: begin
            if (wd_expired) begin
              timeout <= 1'b1;
              state   <= ST_FAIL;
            end else if (prog_done) begin
              rd_start <= 1'b1;
              state    <= ST_RD;
            end
          end
          ST_RD: begin
            done_q <= '0;
            state  <= ST_RD_WAIT;
          end
          ST_RD_WAIT: begin
            done_q <= done_nxt;
            if (wd_expired) begin
              timeout <= 1'b1;
              state   <= ST_FAIL;
            end else if (&done_nxt) begin
              pass_cnt    <= pass_cnt + cnt_t'(1);
              rd_in_round <= rd_in_round + cnt_t'(1);
              state       <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            if (fail || bad) begin
              state <= ST_FAIL;
            end else if (stop_req || stop) begin
              state <= ST_DONE;
            end else if (32'(rd_in_round) < RD_PASSES) begin
              rd_start <= 1'b1;
              state    <= ST_RD;
            end else begin
              round_cnt <= round_inc;
              if ((ROUNDS != 0) && (round_inc == cnt_t'(ROUNDS))) begin
                state <= ST_DONE;
              end else begin
                for (int unsigned n = 0; n < N_BANKS; n++)
                  keys[n] <= bank_key(round_inc, n);
                rd_in_round <= '0;
                prog_start  <= 1'b1;
                state       <= ST_PROG;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
